// File: rtl/dds_pkg.sv
// ----------------------------------------------------------------------------
// dds_pkg
// Shared definitions for the DDS voice bank: default phase width, the
// sweep/idle state encoding and a phase word typedef at the default width.
// ----------------------------------------------------------------------------
package dds_pkg;

    localparam int PHASE_W_DEF = 32;

    // IDLE serves requests; CLEAR walks the phase RAM writing zeros.
    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    typedef logic [PHASE_W_DEF-1:0] phase_t;

endpackage

// File: rtl/voice_phase_ram.sv
// ----------------------------------------------------------------------------
// voice_phase_ram
// Simple dual-port phase store: one write port, one synchronous read port,
// DEPTH x WIDTH, no reset. Read data reflects the address presented at the
// previous clock edge. Read-during-write behaviour is not relied upon.
//
// Ports:
//   clk    - clock
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address, sampled on the rising edge
//   rdata  - registered read data
// ----------------------------------------------------------------------------
module voice_phase_ram #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/dds_voice_bank.sv
// ----------------------------------------------------------------------------
// dds_voice_bank
// Multi-voice DDS phase accumulator bank. Each accepted request adds in_delta
// to the stored phase of in_voice, writes the sum back and emits it one cycle
// later. After reset, and on a clear pulse, the RAM is swept to zero over
// NUM_VOICES cycles during which no requests are taken.
//
// Ports:
//   clk        - system clock (rising edge)
//   reset_n    - asynchronous active-low reset
//   in_valid   - request strobe
//   in_ready   - request accepted when in_valid && in_ready
//   in_voice   - voice slot to advance
//   in_delta   - unsigned phase increment
//   in_retrig  - treat the stored phase as zero for this request
//   clear      - one-cycle pulse to zero every voice
//   busy       - clear sweep in progress
//   out_valid  - one-cycle result strobe
//   out_voice  - voice of the result
//   out_phase  - new phase of that voice
//   out_wrap   - carry out of the addition
// ----------------------------------------------------------------------------
module dds_voice_bank
    import dds_pkg::*;
#(
    parameter  int NUM_VOICES = 256,
    parameter  int PHASE_W    = PHASE_W_DEF,
    localparam int VOICE_W    = $clog2(NUM_VOICES)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [VOICE_W-1:0] in_voice,
    input  logic [PHASE_W-1:0] in_delta,
    input  logic               in_retrig,
    input  logic               clear,
    output logic               busy,
    output logic               out_valid,
    output logic [VOICE_W-1:0] out_voice,
    output logic [PHASE_W-1:0] out_phase,
    output logic               out_wrap
);

    localparam logic [VOICE_W-1:0] LAST_VOICE = VOICE_W'(NUM_VOICES - 1);
    localparam logic [VOICE_W:0]   VOICE_LIM  = (VOICE_W + 1)'(NUM_VOICES);

    state_t               state;
    state_t               state_next;
    logic [VOICE_W-1:0]   sweep_cnt;

    logic                 s1_valid;
    logic [VOICE_W-1:0]   s1_voice;
    logic [PHASE_W-1:0]   s1_delta;
    logic                 s1_retrig;

    logic [PHASE_W-1:0]   ram_rdata;
    logic                 ram_we;
    logic [VOICE_W-1:0]   ram_waddr;
    logic [PHASE_W-1:0]   ram_wdata;

    logic [PHASE_W-1:0]   old_phase;
    logic [PHASE_W:0]     sum;
    logic                 accept;
    logic                 in_range;

    assign accept   = in_valid && in_ready;
    assign in_range = ({1'b0, in_voice} < VOICE_LIM);

    // State register and sweep address counter. The counter is held at zero
    // outside the sweep so every entry into CLEAR starts from address 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= CLEAR;
            sweep_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == CLEAR && state_next == CLEAR) begin
                sweep_cnt <= sweep_cnt + 1'b1;
            end else begin
                sweep_cnt <= '0;
            end
        end
    end

    // Next state: leave the sweep after zeroing the last slot; a clear pulse
    // is only honoured while idle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (clear) state_next = CLEAR;
            CLEAR:   if (sweep_cnt == LAST_VOICE) state_next = IDLE;
            default: state_next = CLEAR;
        endcase
    end

    // Outputs of the FSM: handshake, busy flag and the RAM write mux. While
    // sweeping the write port belongs to the sweep; otherwise it carries the
    // pipeline result being registered to the outputs on the same edge.
    always_comb begin
        busy      = (state == CLEAR);
        in_ready  = (state == IDLE) && !clear;
        ram_we    = s1_valid;
        ram_waddr = s1_voice;
        ram_wdata = sum[PHASE_W-1:0];
        if (state == CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = sweep_cnt;
            ram_wdata = '0;
        end
    end

    // The request in S1 may target the voice whose result was written on the
    // same edge its RAM read was issued; that read is stale, so the just-
    // registered output is used instead. Retrigger overrides both sources.
    always_comb begin
        old_phase = ram_rdata;
        if (out_valid && out_voice == s1_voice) begin
            old_phase = out_phase;
        end
        if (s1_retrig) begin
            old_phase = '0;
        end
        sum = {1'b0, old_phase} + {1'b0, s1_delta};
    end

    // Request capture and result registers. Out-of-range voices never enter
    // S1, so they produce neither an output nor a write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid  <= 1'b0;
            s1_voice  <= '0;
            s1_delta  <= '0;
            s1_retrig <= 1'b0;
            out_valid <= 1'b0;
            out_voice <= '0;
            out_phase <= '0;
            out_wrap  <= 1'b0;
        end else begin
            s1_valid <= accept && in_range;
            if (accept) begin
                s1_voice  <= in_voice;
                s1_delta  <= in_delta;
                s1_retrig <= in_retrig;
            end
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_voice <= s1_voice;
                out_phase <= sum[PHASE_W-1:0];
                out_wrap  <= sum[PHASE_W];
            end
        end
    end

    voice_phase_ram #(
        .DEPTH (NUM_VOICES),
        .WIDTH (PHASE_W),
        .AW    (VOICE_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (in_voice),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_dds_voice_bank.sv
// ----------------------------------------------------------------------------
// tb_dds_voice_bank
// Self-checking bench for dds_voice_bank with 8 voices and 32-bit phase.
// A reference model holds one phase per voice as plain integers, applies each
// accepted request immediately and expects the result one cycle later.
// ----------------------------------------------------------------------------
module tb_dds_voice_bank;

    localparam int NV = 8;
    localparam int PW = 32;
    localparam int VW = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [VW-1:0] in_voice;
    logic [PW-1:0] in_delta;
    logic          in_retrig;
    logic          clear;
    logic          busy;
    logic          out_valid;
    logic [VW-1:0] out_voice;
    logic [PW-1:0] out_phase;
    logic          out_wrap;

    int check_count = 0;
    int pass_count  = 0;

    // Reference model state.
    logic [PW-1:0] model_phase [NV];
    int            sweep_left;
    bit            pend_valid;
    int            pend_voice;
    logic [PW:0]   pend_sum;

    dds_voice_bank #(
        .NUM_VOICES (NV),
        .PHASE_W    (PW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_voice  (in_voice),
        .in_delta  (in_delta),
        .in_retrig (in_retrig),
        .clear     (clear),
        .busy      (busy),
        .out_valid (out_valid),
        .out_voice (out_voice),
        .out_phase (out_phase),
        .out_wrap  (out_wrap)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        check_count++;
        if (observed === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    task automatic modelSweepStart();
        sweep_left = NV;
        for (int i = 0; i < NV; i++) model_phase[i] = '0;
    endtask

    // One clock cycle: drive inputs shortly after a rising edge, check the
    // handshake, advance the model, then check the outputs after the edge.
    task automatic applyStimulus(input bit v, input int voice,
                                 input logic [PW-1:0] delta,
                                 input bit retrig, input bit clr);
        bit          exp_ready;
        bit          new_valid;
        int          new_voice;
        logic [PW:0] new_sum;
        logic [PW:0] base;
        in_valid  = v;
        in_voice  = voice[VW-1:0];
        in_delta  = delta;
        in_retrig = retrig;
        clear     = clr;
        #1;
        exp_ready = (sweep_left == 0) && !clr;
        checkOutput("in_ready", {63'd0, in_ready}, {63'd0, exp_ready});
        checkOutput("busy", {63'd0, busy}, {63'd0, sweep_left != 0});
        new_valid = 1'b0;
        new_voice = 0;
        new_sum   = '0;
        if (v && exp_ready && voice < NV) begin
            base = retrig ? '0 : {1'b0, model_phase[voice]};
            new_sum = base + {1'b0, delta};
            model_phase[voice] = new_sum[PW-1:0];
            new_valid = 1'b1;
            new_voice = voice;
        end
        if (sweep_left > 0) begin
            sweep_left--;
        end else if (clr) begin
            modelSweepStart();
        end
        @(posedge clk);
        #1;
        checkOutput("out_valid", {63'd0, out_valid}, {63'd0, pend_valid});
        if (pend_valid) begin
            checkOutput("out_voice", {61'd0, out_voice}, 64'(pend_voice));
            checkOutput("out_phase", {32'd0, out_phase}, {32'd0, pend_sum[PW-1:0]});
            checkOutput("out_wrap", {63'd0, out_wrap}, {63'd0, pend_sum[PW]});
        end
        pend_valid = new_valid;
        pend_voice = new_voice;
        pend_sum   = new_sum;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_voice  = '0;
        in_delta  = '0;
        in_retrig = 1'b0;
        clear     = 1'b0;
        pend_valid = 1'b0;
        pend_voice = 0;
        pend_sum   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("rst_out_voice", {61'd0, out_voice}, 64'd0);
        checkOutput("rst_out_phase", {32'd0, out_phase}, 64'd0);
        checkOutput("rst_out_wrap", {63'd0, out_wrap}, 64'd0);
        checkOutput("rst_busy", {63'd0, busy}, 64'd1);
        checkOutput("rst_in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        modelSweepStart();

        // Post-reset sweep, then the first request.
        idleCycles(NV);
        applyStimulus(1'b1, 3, 32'd5, 1'b0, 1'b0);
        idleCycles(1);
        checkOutput("first_req", {32'd0, out_phase}, 64'd5);

        // Interleaved independent voices.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 0, 32'h100, 1'b0, 1'b0);
            applyStimulus(1'b1, 1, 32'h10, 1'b0, 1'b0);
        end
        idleCycles(1);
        checkOutput("interleave_last", {32'd0, out_phase}, 64'h30);

        // Back-to-back on one voice exercises forwarding.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2, 32'd7, 1'b0, 1'b0);
        idleCycles(1);
        checkOutput("b2b_last", {32'd0, out_phase}, 64'd28);

        // Wrap past 2^32.
        applyStimulus(1'b1, 4, 32'hC000_0000, 1'b0, 1'b0);
        applyStimulus(1'b1, 4, 32'hC000_0000, 1'b0, 1'b0);
        idleCycles(1);
        checkOutput("wrap_phase", {32'd0, out_phase}, 64'h8000_0000);
        checkOutput("wrap_flag", {63'd0, out_wrap}, 64'd1);

        // Retrigger then continue.
        applyStimulus(1'b1, 5, 32'h1234, 1'b0, 1'b0);
        applyStimulus(1'b1, 5, 32'h10, 1'b1, 1'b0);
        idleCycles(1);
        checkOutput("retrig_phase", {32'd0, out_phase}, 64'h10);
        checkOutput("retrig_wrap", {63'd0, out_wrap}, 64'd0);
        applyStimulus(1'b1, 5, 32'h10, 1'b0, 1'b0);
        idleCycles(1);
        checkOutput("retrig_next", {32'd0, out_phase}, 64'h20);

        // Clear collides with a request in flight and a new request.
        applyStimulus(1'b1, 6, 32'h77, 1'b0, 1'b0);
        applyStimulus(1'b1, 6, 32'h1, 1'b0, 1'b1);
        checkOutput("clr_s1_result", {32'd0, out_phase}, 64'h77);
        idleCycles(NV);
        for (int i = 0; i < NV; i++) applyStimulus(1'b1, i, 32'd1, 1'b0, 1'b0);
        idleCycles(1);
        checkOutput("clr_voice7", {32'd0, out_phase}, 64'd1);

        // Randomized traffic, occasionally clears, hot voices for forwarding.
        for (int i = 0; i < 400; i++) begin
            bit          v;
            int          vc;
            logic [PW-1:0] d;
            v  = ($urandom_range(0, 3) != 0);
            vc = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 1))
                                            : int'($urandom_range(0, NV - 1));
            d  = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 255);
            applyStimulus(v, vc, d, ($urandom_range(0, 7) == 0),
                          ($urandom_range(0, 59) == 0));
        end

        // Reset in the middle of traffic restarts the sweep.
        applyStimulus(1'b1, 2, 32'h55, 1'b0, 1'b0);
        reset_n  = 1'b0;
        in_valid = 1'b0;
        #1;
        checkOutput("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("midrst_busy", {63'd0, busy}, 64'd1);
        @(posedge clk);
        #1;
        reset_n    = 1'b1;
        pend_valid = 1'b0;
        modelSweepStart();
        idleCycles(NV);
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b1, int'($urandom_range(0, NV - 1)),
                          $urandom, 1'b0, 1'b0);
        end
        idleCycles(2);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
